// File: rtl/exe_stage.sv
// Execute stage of the 5-stage ARM pipeline: operand forwarding, Val2 generation,
// ALU, branch target, NZCV status register and the EXE/MEM pipeline register.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        WB_EN,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic        B,
    input  logic        S,
    input  logic [3:0]  EXE_CMD,
    input  logic [31:0] PC,
    input  logic [31:0] VAL_RN,
    input  logic [31:0] VAL_RM,
    input  logic        IMM,
    input  logic [11:0] ShiftOperand,
    input  logic [23:0] Signed_IMM_24,
    input  logic [3:0]  Dest,
    input  logic [1:0]  SEL_SRC1,
    input  logic [1:0]  SEL_SRC2,
    input  logic [31:0] MEM_FWD,
    input  logic [31:0] WB_FWD,
    output logic        Branch_Taken,
    output logic [31:0] Br_Addr,
    output logic [3:0]  Status,
    output logic        MEM_WB_EN,
    output logic        MEM_MEM_R_EN,
    output logic        MEM_MEM_W_EN,
    output logic [31:0] MEM_ALU_Res,
    output logic [31:0] MEM_Val_Rm,
    output logic [3:0]  MEM_Dest
);

    logic [31:0] op1_s;
    logic [31:0] rm_s;
    logic [31:0] val2_s;
    logic [63:0] imm_rot_s;
    logic [63:0] rm_ror_s;
    logic [4:0]  sh_amt_s;
    logic        arith_s;
    logic        is_sub_s;
    logic        cin_s;
    logic [31:0] b_op_s;
    logic [32:0] sum_s;
    logic [31:0] res_s;
    logic [3:0]  flags_s;

    logic [3:0]  status_q;
    logic [3:0]  status_d;
    logic        wb_en_q;
    logic        mem_r_en_q;
    logic        mem_w_en_q;
    logic [31:0] alu_res_q;
    logic [31:0] val_rm_q;
    logic [3:0]  dest_q;

    // Forwarding muxes; select 11 falls back to the register-file value.
    always_comb begin
        op1_s = VAL_RN;
        rm_s  = VAL_RM;
        case (SEL_SRC1)
            2'b01:   op1_s = MEM_FWD;
            2'b10:   op1_s = WB_FWD;
            default: op1_s = VAL_RN;
        endcase
        case (SEL_SRC2)
            2'b01:   rm_s = MEM_FWD;
            2'b10:   rm_s = WB_FWD;
            default: rm_s = VAL_RM;
        endcase
    end

    // Rotations as a right shift of a doubled word, so an amount of 0 is a pass-through.
    assign sh_amt_s  = ShiftOperand[11:7];
    assign imm_rot_s = {24'd0, ShiftOperand[7:0], 24'd0, ShiftOperand[7:0]} >> {ShiftOperand[11:8], 1'b0};
    assign rm_ror_s  = {rm_s, rm_s} >> sh_amt_s;

    // Operand-2 generation: memory offset, rotated immediate or shifted register.
    always_comb begin
        val2_s = 32'd0;
        if (MEM_R_EN || MEM_W_EN) begin
            val2_s = {20'd0, ShiftOperand};
        end else if (IMM) begin
            val2_s = imm_rot_s[31:0];
        end else begin
            case (ShiftOperand[6:5])
                2'b00:   val2_s = rm_s << sh_amt_s;
                2'b01:   val2_s = rm_s >> sh_amt_s;
                2'b10:   val2_s = $unsigned($signed(rm_s) >>> sh_amt_s);
                2'b11:   val2_s = rm_ror_s[31:0];
                default: val2_s = rm_s;
            endcase
        end
    end

    // Adder control: subtraction is Op1 + ~Val2 + carry-in.
    always_comb begin
        arith_s  = 1'b0;
        is_sub_s = 1'b0;
        cin_s    = 1'b0;
        case (EXE_CMD)
            4'b0010: begin arith_s = 1'b1; is_sub_s = 1'b0; cin_s = 1'b0;        end
            4'b0011: begin arith_s = 1'b1; is_sub_s = 1'b0; cin_s = status_q[1]; end
            4'b0100: begin arith_s = 1'b1; is_sub_s = 1'b1; cin_s = 1'b1;        end
            4'b0101: begin arith_s = 1'b1; is_sub_s = 1'b1; cin_s = status_q[1]; end
            default: begin arith_s = 1'b0; is_sub_s = 1'b0; cin_s = 1'b0;        end
        endcase
    end

    assign b_op_s = is_sub_s ? ~val2_s : val2_s;
    assign sum_s  = {1'b0, op1_s} + {1'b0, b_op_s} + {32'd0, cin_s};

    // ALU result selection.
    always_comb begin
        res_s = 32'd0;
        case (EXE_CMD)
            4'b0001: res_s = val2_s;
            4'b1001: res_s = ~val2_s;
            4'b0010: res_s = sum_s[31:0];
            4'b0011: res_s = sum_s[31:0];
            4'b0100: res_s = sum_s[31:0];
            4'b0101: res_s = sum_s[31:0];
            4'b0110: res_s = op1_s & val2_s;
            4'b0111: res_s = op1_s | val2_s;
            4'b1000: res_s = op1_s ^ val2_s;
            default: res_s = 32'd0;
        endcase
    end

    // New NZCV; logical and move ops keep the current C and V.
    always_comb begin
        flags_s[3] = res_s[31];
        flags_s[2] = (res_s == 32'd0);
        if (arith_s) begin
            flags_s[1] = sum_s[32];
            flags_s[0] = (op1_s[31] == b_op_s[31]) && (sum_s[31] != op1_s[31]);
        end else begin
            flags_s[1] = status_q[1];
            flags_s[0] = status_q[0];
        end
    end

    always_comb begin
        status_d = status_q;
        if (S && !freeze) begin
            status_d = flags_s;
        end else begin
            status_d = status_q;
        end
    end

    // Status register.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= 4'd0;
        end else begin
            status_q <= status_d;
        end
    end

    // EXE/MEM pipeline register, held while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            alu_res_q  <= 32'd0;
            val_rm_q   <= 32'd0;
            dest_q     <= 4'd0;
        end else if (!freeze) begin
            wb_en_q    <= WB_EN;
            mem_r_en_q <= MEM_R_EN;
            mem_w_en_q <= MEM_W_EN;
            alu_res_q  <= res_s;
            val_rm_q   <= rm_s;
            dest_q     <= Dest;
        end
    end

    assign Branch_Taken = B;
    assign Br_Addr      = PC + {{6{Signed_IMM_24[23]}}, Signed_IMM_24, 2'b00};
    assign Status       = status_q;
    assign MEM_WB_EN    = wb_en_q;
    assign MEM_MEM_R_EN = mem_r_en_q;
    assign MEM_MEM_W_EN = mem_w_en_q;
    assign MEM_ALU_Res  = alu_res_q;
    assign MEM_Val_Rm   = val_rm_q;
    assign MEM_Dest     = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: expected EXE/MEM contents are queued when an
// instruction is driven and compared after the following clock edge.
module tb_exe_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        WB_EN, MEM_R_EN, MEM_W_EN, B, S, IMM;
    logic [3:0]  EXE_CMD, Dest;
    logic [31:0] PC, VAL_RN, VAL_RM, MEM_FWD, WB_FWD;
    logic [11:0] ShiftOperand;
    logic [23:0] Signed_IMM_24;
    logic [1:0]  SEL_SRC1, SEL_SRC2;
    logic        Branch_Taken;
    logic [31:0] Br_Addr;
    logic [3:0]  Status;
    logic        MEM_WB_EN, MEM_MEM_R_EN, MEM_MEM_W_EN;
    logic [31:0] MEM_ALU_Res, MEM_Val_Rm;
    logic [3:0]  MEM_Dest;

    typedef struct packed {
        logic [2:0]  ctl;
        logic [3:0]  dest;
        logic [31:0] rm;
        logic [31:0] res;
        logic [3:0]  status;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   passed = 0;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .B(B), .S(S), .EXE_CMD(EXE_CMD), .PC(PC),
        .VAL_RN(VAL_RN), .VAL_RM(VAL_RM), .IMM(IMM),
        .ShiftOperand(ShiftOperand), .Signed_IMM_24(Signed_IMM_24), .Dest(Dest),
        .SEL_SRC1(SEL_SRC1), .SEL_SRC2(SEL_SRC2),
        .MEM_FWD(MEM_FWD), .WB_FWD(WB_FWD),
        .Branch_Taken(Branch_Taken), .Br_Addr(Br_Addr), .Status(Status),
        .MEM_WB_EN(MEM_WB_EN), .MEM_MEM_R_EN(MEM_MEM_R_EN), .MEM_MEM_W_EN(MEM_MEM_W_EN),
        .MEM_ALU_Res(MEM_ALU_Res), .MEM_Val_Rm(MEM_Val_Rm), .MEM_Dest(MEM_Dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        WB_EN = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; B = 1'b0; S = 1'b0;
        IMM = 1'b0; EXE_CMD = 4'd0; Dest = 4'd0; PC = 32'd0;
        VAL_RN = 32'd0; VAL_RM = 32'd0; MEM_FWD = 32'd0; WB_FWD = 32'd0;
        ShiftOperand = 12'd0; Signed_IMM_24 = 24'd0;
        SEL_SRC1 = 2'b00; SEL_SRC2 = 2'b00; freeze = 1'b0;
    endtask

    task automatic expect_out(input logic [2:0] ctl, input logic [3:0] dest,
                              input logic [31:0] rm, input logic [31:0] res,
                              input logic [3:0] status);
        exp_t e;
        e.ctl = ctl; e.dest = dest; e.rm = rm; e.res = res; e.status = status;
        sb.push_back(e);
        last_exp = e;
    endtask

    task automatic tick_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            $error("FAIL %s: scoreboard empty, observed %h expected an entry", tag, MEM_ALU_Res);
        end else begin
            e = sb.pop_front();
            chk({tag, ".res"}, {32'd0, MEM_ALU_Res}, {32'd0, e.res});
            chk({tag, ".status"}, {60'd0, Status}, {60'd0, e.status});
            chk({tag, ".ctl_dest_rm"},
                {25'd0, MEM_WB_EN, MEM_MEM_R_EN, MEM_MEM_W_EN, MEM_Dest, MEM_Val_Rm},
                {25'd0, e.ctl, e.dest, e.rm});
        end
    endtask

    initial begin
        idle();
        // Reset with busy inputs and freeze asserted
        rst = 1'b1; freeze = 1'b1; S = 1'b1; WB_EN = 1'b1; MEM_W_EN = 1'b1;
        EXE_CMD = 4'b0010; VAL_RN = 32'h1234_5678; VAL_RM = 32'hDEAD_BEEF;
        IMM = 1'b1; ShiftOperand = 12'h0FF; Dest = 4'd9;
        for (int i = 0; i < 2; i++) begin
            expect_out(3'b000, 4'd0, 32'd0, 32'd0, 4'b0000);
            tick_check("reset");
        end
        rst = 1'b0;

        // ADDS 0xFFFFFFFF + 1 -> 0, Z and C set
        idle(); WB_EN = 1'b1; S = 1'b1; EXE_CMD = 4'b0010; VAL_RN = 32'hFFFF_FFFF;
        IMM = 1'b1; ShiftOperand = 12'h001; Dest = 4'd3; VAL_RM = 32'h0000_AAAA;
        expect_out(3'b100, 4'd3, 32'h0000_AAAA, 32'h0000_0000, 4'b0110);
        tick_check("adds");

        // ADC 0 + 0 + C -> 1
        idle(); WB_EN = 1'b1; EXE_CMD = 4'b0011; IMM = 1'b1; Dest = 4'd4;
        expect_out(3'b100, 4'd4, 32'd0, 32'h0000_0001, 4'b0110);
        tick_check("adc");

        // SUBS 0x80000000 - 1 -> overflow
        idle(); WB_EN = 1'b1; S = 1'b1; EXE_CMD = 4'b0100; VAL_RN = 32'h8000_0000;
        IMM = 1'b1; ShiftOperand = 12'h001; Dest = 4'd5;
        expect_out(3'b100, 4'd5, 32'd0, 32'h7FFF_FFFF, 4'b0011);
        tick_check("subs");

        // CMP 5,5
        idle(); S = 1'b1; EXE_CMD = 4'b0100; VAL_RN = 32'd5; IMM = 1'b1; ShiftOperand = 12'h005;
        expect_out(3'b000, 4'd0, 32'd0, 32'd0, 4'b0110);
        tick_check("cmp");

        // MOV rotated immediate 0xFF ror 4
        idle(); WB_EN = 1'b1; EXE_CMD = 4'b0001; IMM = 1'b1; ShiftOperand = 12'h2FF; Dest = 4'd1;
        expect_out(3'b100, 4'd1, 32'd0, 32'hF000_000F, 4'b0110);
        tick_check("mov_imm");

        // MOV ASR #4
        idle(); WB_EN = 1'b1; EXE_CMD = 4'b0001; VAL_RM = 32'h8000_0000; ShiftOperand = 12'h240; Dest = 4'd2;
        expect_out(3'b100, 4'd2, 32'h8000_0000, 32'hF800_0000, 4'b0110);
        tick_check("asr4");

        // MOV ROR #0
        idle(); WB_EN = 1'b1; EXE_CMD = 4'b0001; VAL_RM = 32'h1234_5678; ShiftOperand = 12'h060; Dest = 4'd2;
        expect_out(3'b100, 4'd2, 32'h1234_5678, 32'h1234_5678, 4'b0110);
        tick_check("ror0");

        // LDR offset 0xFFF overrides the shifter decoding
        idle(); WB_EN = 1'b1; MEM_R_EN = 1'b1; EXE_CMD = 4'b0010; ShiftOperand = 12'hFFF; Dest = 4'd7;
        expect_out(3'b110, 4'd7, 32'd0, 32'h0000_0FFF, 4'b0110);
        tick_check("ldr_off");

        // MVNS 0: N set, C/V kept from previous status
        idle(); WB_EN = 1'b1; S = 1'b1; EXE_CMD = 4'b1001; IMM = 1'b1; Dest = 4'd8;
        expect_out(3'b100, 4'd8, 32'd0, 32'hFFFF_FFFF, 4'b1010);
        tick_check("mvns");

        // EOR 0xFF ^ 0x0F
        idle(); WB_EN = 1'b1; EXE_CMD = 4'b1000; VAL_RN = 32'h0000_00FF; IMM = 1'b1; ShiftOperand = 12'h00F; Dest = 4'd6;
        expect_out(3'b100, 4'd6, 32'd0, 32'h0000_00F0, 4'b1010);
        tick_check("eor");

        // Forwarding: Op1 from MEM_FWD, Rm from WB_FWD
        idle(); WB_EN = 1'b1; EXE_CMD = 4'b0010; VAL_RN = 32'd999; MEM_FWD = 32'd10;
        SEL_SRC1 = 2'b01; SEL_SRC2 = 2'b10; WB_FWD = 32'h55; VAL_RM = 32'h66;
        IMM = 1'b1; ShiftOperand = 12'h003; Dest = 4'd10;
        expect_out(3'b100, 4'd10, 32'h55, 32'd13, 4'b1010);
        tick_check("fwd");

        // Frozen ADDS: outputs and flags hold
        idle(); WB_EN = 1'b1; S = 1'b1; EXE_CMD = 4'b0010; IMM = 1'b1; ShiftOperand = 12'h007;
        Dest = 4'd11; VAL_RM = 32'h77; freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out(last_exp.ctl, last_exp.dest, last_exp.rm, last_exp.res, last_exp.status);
            tick_check("freeze");
        end
        freeze = 1'b0;
        expect_out(3'b100, 4'd11, 32'h77, 32'd7, 4'b0000);
        tick_check("unfreeze");

        // SBC with C=0: 10 - 3 - 1
        idle(); WB_EN = 1'b1; S = 1'b1; EXE_CMD = 4'b0101; VAL_RN = 32'd10; IMM = 1'b1; ShiftOperand = 12'h003; Dest = 4'd12;
        expect_out(3'b100, 4'd12, 32'd0, 32'd6, 4'b0010);
        tick_check("sbcs");

        // Branch target is combinational
        idle(); B = 1'b1; PC = 32'h0000_0100; Signed_IMM_24 = 24'hFFFFFF;
        #1;
        chk("br_taken", {63'd0, Branch_Taken}, 64'd1);
        chk("br_addr", {32'd0, Br_Addr}, 64'h0000_0000_0000_00FC);
        Signed_IMM_24 = 24'h000010; B = 1'b0;
        #1;
        chk("br_fwd", {32'd0, Br_Addr}, 64'h0000_0000_0000_0140);
        chk("br_not_taken", {63'd0, Branch_Taken}, 64'd0);
        expect_out(3'b000, 4'd0, 32'd0, 32'd0, 4'b0010);
        tick_check("branch");

        // Reset during a stall clears everything
        idle(); WB_EN = 1'b1; S = 1'b1; EXE_CMD = 4'b0111; VAL_RN = 32'hF; freeze = 1'b1; rst = 1'b1;
        expect_out(3'b000, 4'd0, 32'd0, 32'd0, 4'b0000);
        tick_check("reset_stall");
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
